// File: rtl/tristate_bus_ctrl_pkg.sv
// Shared definitions for the registered bidirectional bus port.
// State encoding and counter sizing helper.
package tristate_bus_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LEAD  = 2'd1,
      ST_DRIVE = 2'd2,
      ST_HOLD  = 2'd3
   } state_e;

   // Never returns 0 so the counter always has at least one bit.
   function automatic int cnt_width(input int lead, input int hold);
      int m;
      m = (lead > hold) ? lead : hold;
      if (m < 1) m = 1;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/tristate_bus_ctrl_sync.sv
// Multi-bit flop-chain synchroniser for asynchronous input paths.
// Reset clears every stage.
module bus_sync_nbit #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] ff;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ff <= '0;
      end else begin
         ff <= {ff[SYNC_STAGES-2:0], d};
      end
   end

   assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/tristate_bus_ctrl.sv
// Registered tristate bus port with lead/hold turnaround dead time
// and synchronised read capture of the external bus.
module tristate_bus_ctrl
   import tristate_bus_ctrl_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int LEAD_CYC    = 1,
   parameter int HOLD_CYC    = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             drive_req,
   input  logic [WIDTH-1:0] wr_data,
   inout  wire  [WIDTH-1:0] bus,
   input  logic             rd_strobe,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic             driving,
   output logic             busy
);

   localparam int CW = cnt_width(LEAD_CYC, HOLD_CYC);
   localparam logic [CW-1:0] LEAD_INIT =
      CW'((LEAD_CYC > 0) ? LEAD_CYC - 1 : 0);
   localparam logic [CW-1:0] HOLD_INIT =
      CW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             load;
   logic             oe_q;
   logic [WIDTH-1:0] dout_q;
   logic [WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] rd_data_q;
   logic             strb_q;
   logic             rd_valid_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (drive_req) begin
               load = 1'b1;
               if (LEAD_CYC == 0) begin
                  state_d = ST_DRIVE;
               end else begin
                  state_d = ST_LEAD;
                  cnt_d   = LEAD_INIT;
               end
            end
         end
         ST_LEAD: begin
            load = 1'b1;
            if (!drive_req) begin
               state_d = ST_IDLE;
            end else if (cnt_q == '0) begin
               state_d = ST_DRIVE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_DRIVE: begin
            if (drive_req) begin
               load = 1'b1;
            end else if (HOLD_CYC == 0) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_HOLD;
               cnt_d   = HOLD_INIT;
            end
         end
         ST_HOLD: begin
            // Data stays frozen; a re-request skips the lead time.
            if (drive_req) begin
               state_d = ST_DRIVE;
            end else if (cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         oe_q    <= 1'b0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         oe_q    <= (state_d == ST_DRIVE) || (state_d == ST_HOLD);
         if (load) dout_q <= wr_data;
      end
   end

   bus_sync_nbit #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (bus),
      .q       (sync_q)
   );

   // While driving, read back our own data rather than the synchroniser.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_data_q  <= '0;
         strb_q     <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         if (rd_strobe) rd_data_q <= oe_q ? dout_q : sync_q;
         strb_q     <= rd_strobe;
         rd_valid_q <= strb_q;
      end
   end

   assign bus      = oe_q ? dout_q : {WIDTH{1'bz}};
   assign driving  = oe_q;
   assign busy     = (state_q != ST_IDLE);
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_tristate_bus_ctrl.sv
// Bench for tristate_bus_ctrl: directed turnaround/read scenarios plus
// random traffic against a cycle-level behavioural model.
module tb_tristate_bus_ctrl;

   localparam int M_LEAD = 1;
   localparam int M_HOLD = 1;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic       drive_req = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       rd_strobe = 1'b0;
   wire  [7:0] bus;
   logic [7:0] rd_data;
   logic       rd_valid, driving, busy;
   logic       ext_en = 1'b0;
   logic [7:0] ext_val = 8'h00;

   assign bus = ext_en ? ext_val : 8'hzz;

   tristate_bus_ctrl #(
      .WIDTH(8), .LEAD_CYC(M_LEAD), .HOLD_CYC(M_HOLD), .SYNC_STAGES(2)
   ) u_dut (
      .clk(clk), .reset_n(reset_n), .drive_req(drive_req),
      .wr_data(wr_data), .bus(bus), .rd_strobe(rd_strobe),
      .rd_data(rd_data), .rd_valid(rd_valid), .driving(driving),
      .busy(busy)
   );

   logic       req3 = 1'b0;
   logic [7:0] wr3 = 8'h00;
   logic       strb3 = 1'b0;
   wire  [7:0] bus3;
   logic [7:0] rd3;
   logic       rv3, drv3, busy3;

   tristate_bus_ctrl #(
      .WIDTH(8), .LEAD_CYC(3), .HOLD_CYC(1), .SYNC_STAGES(2)
   ) u_dut3 (
      .clk(clk), .reset_n(reset_n), .drive_req(req3),
      .wr_data(wr3), .bus(bus3), .rd_strobe(strb3),
      .rd_data(rd3), .rd_valid(rv3), .driving(drv3),
      .busy(busy3)
   );

   logic        req16 = 1'b0;
   logic [15:0] wr16 = 16'h0000;
   logic        strb16 = 1'b0;
   wire  [15:0] bus16;
   logic [15:0] rd16;
   logic        rv16, drv16, busy16;

   tristate_bus_ctrl #(
      .WIDTH(16), .LEAD_CYC(0), .HOLD_CYC(0), .SYNC_STAGES(3)
   ) u_dut16 (
      .clk(clk), .reset_n(reset_n), .drive_req(req16),
      .wr_data(wr16), .bus(bus16), .rd_strobe(strb16),
      .rd_data(rd16), .rd_valid(rv16), .driving(drv16),
      .busy(busy16)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [15:0] got,
                      input logic [15:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Behavioural model of the main instance
   bit         m_en, m_lead, m_hold, m_rv, m_sd;
   int         m_le, m_he;
   logic [7:0] m_data, m_rd;
   logic [7:0] m_hist[$];

   task automatic model_reset();
      m_en = 0; m_lead = 0; m_hold = 0; m_rv = 0; m_sd = 0;
      m_le = 0; m_he = 0;
      m_data = 8'h00; m_rd = 8'h00;
      m_hist = {8'h00, 8'h00};
   endtask

   task automatic tick();
      logic       r, s;
      logic [7:0] w, bnow, sold;
      r = drive_req; w = wr_data; s = rd_strobe;
      bnow = m_en ? m_data : (ext_en ? ext_val : 8'hxx);
      @(posedge clk);
      sold = m_hist.pop_front();
      m_hist.push_back(bnow);
      m_rv = m_sd;
      m_sd = s;
      if (s) m_rd = m_en ? m_data : sold;
      if (m_lead) begin
         m_data = w;
         if (!r) m_lead = 0;
         else if (m_le >= M_LEAD) begin m_lead = 0; m_en = 1; end
         else m_le++;
      end else if (!m_en) begin
         if (r) begin
            m_data = w; m_le = 1;
            if (M_LEAD == 0) m_en = 1; else m_lead = 1;
         end
      end else if (m_hold) begin
         if (r) m_hold = 0;
         else if (m_he >= M_HOLD) begin m_hold = 0; m_en = 0; end
         else m_he++;
      end else begin
         if (r) m_data = w;
         else if (M_HOLD == 0) m_en = 0;
         else begin m_hold = 1; m_he = 1; end
      end
      #1;
      if (m_en) chk("bus_drv", bus, m_data);
      chk("driving", driving, m_en);
      chk("busy", busy, m_en | m_lead);
      if (!$isunknown(m_rd)) chk("rd_data", rd_data, m_rd);
      chk("rd_valid", rd_valid, m_rv);
      ext_en = !(m_en || m_lead);
      #1;
      if (ext_en) chk("bus_rel", bus, ext_val);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: timeout reached, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      model_reset();
      ext_en = 1'b1;
      ext_val = 8'hC3;
      #12;
      chk("rst_driving", driving, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_rd_data", rd_data, 8'h00);
      chk("rst_rd_valid", rd_valid, 1'b0);
      chk("rst_bus", bus, 8'hC3);
      reset_n = 1'b1;

      // lead/hold sequencing
      wr_data = 8'hA5; drive_req = 1'b1;
      tick(); chk("t2_lead_off", driving, 1'b0);
      tick(); chk("t2_drive", bus, 8'hA5);
      drive_req = 1'b0;
      tick(); chk("t2_hold", bus, 8'hA5);
      tick(); chk("t2_released", driving, 1'b0);
      chk("t2_rel_bus", bus, 8'hC3);

      // re-request during hold
      wr_data = 8'h11; drive_req = 1'b1;
      tick(); tick(); chk("t4_drive", bus, 8'h11);
      drive_req = 1'b0;
      tick(); chk("t4_hold", bus, 8'h11);
      wr_data = 8'hFF; drive_req = 1'b1;
      tick(); chk("t4_no_gap", driving, 1'b1);
      chk("t4_frozen", bus, 8'h11);
      tick(); chk("t4_new", bus, 8'hFF);
      drive_req = 1'b0;
      tick(); tick();

      // synchronised read and rd_valid pulses
      ext_val = 8'h3C;
      tick(); tick(); tick();
      rd_strobe = 1'b1;
      tick(); chk("t5_rd", rd_data, 8'h3C);
      chk("t5_rv_early", rd_valid, 1'b0);
      rd_strobe = 1'b0;
      tick(); chk("t5_rv", rd_valid, 1'b1);
      tick(); chk("t5_rv_end", rd_valid, 1'b0);
      ext_val = 8'h5A;
      tick(); tick(); tick();
      rd_strobe = 1'b1;
      tick(); tick(); chk("t5_b2b_a", rd_valid, 1'b1);
      rd_strobe = 1'b0;
      tick(); chk("t5_b2b_b", rd_valid, 1'b1);
      tick(); chk("t5_b2b_end", rd_valid, 1'b0);
      chk("t5_rd2", rd_data, 8'h5A);

      // loopback read while driving
      ext_val = 8'hC3;
      wr_data = 8'hA5; drive_req = 1'b1;
      tick(); tick();
      rd_strobe = 1'b1;
      tick(); chk("t5_loop", rd_data, 8'hA5);
      rd_strobe = 1'b0;
      tick(); chk("t1_pre_drive", bus, 8'hA5);

      // asynchronous reset while driving
      reset_n = 1'b0;
      #1;
      chk("t1_driving", driving, 1'b0);
      chk("t1_busy", busy, 1'b0);
      chk("t1_rd_data", rd_data, 8'h00);
      model_reset();
      ext_en = 1'b1;
      #1;
      chk("t1_bus_rel", bus, 8'hC3);
      drive_req = 1'b0;
      #1;
      reset_n = 1'b1;

      // random traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(3) == 0) drive_req = ~drive_req;
         wr_data = 8'($urandom);
         ext_val = 8'($urandom);
         rd_strobe = ($urandom_range(3) == 0);
         tick();
      end
      drive_req = 1'b0; rd_strobe = 1'b0;
      tick(); tick(); tick();

      // abort during long lead, then full lead
      req3 = 1'b1; wr3 = 8'h77;
      tick(); chk("t3_busy", busy3, 1'b1);
      chk("t3_off", drv3, 1'b0);
      req3 = 1'b0;
      tick(); chk("t3_off2", drv3, 1'b0);
      tick(); chk("t3_idle", busy3, 1'b0);
      chk("t3_off3", drv3, 1'b0);
      req3 = 1'b1;
      tick(); chk("t3_lead1", drv3, 1'b0);
      tick(); chk("t3_lead2", drv3, 1'b0);
      tick(); chk("t3_lead3", drv3, 1'b0);
      tick(); chk("t3_drive", drv3, 1'b1);
      chk("t3_bus", bus3, 8'h77);
      req3 = 1'b0;
      tick(); chk("t3_hold", bus3, 8'h77);
      tick(); chk("t3_rel", drv3, 1'b0);

      // zero lead/hold, 16-bit
      wr16 = 16'hBEEF; req16 = 1'b1;
      tick(); chk("t6_drive", drv16, 1'b1);
      chk("t6_bus", bus16, 16'hBEEF);
      req16 = 1'b0;
      tick(); chk("t6_rel", drv16, 1'b0);
      chk("t6_busy", busy16, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
